// File: rtl/ex_mem_buffer.sv
// EX->MEM pipeline buffer: two-entry skid buffer with a registered in_ready
// and a combinational forwarding lookup over the held entries.
module ex_mem_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] reg_write_addr_i,
  input  logic                  reg_write_en_i,
  input  logic [DATA_WIDTH-1:0] reg_write_data_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] reg_write_addr_o,
  output logic                  reg_write_en_o,
  output logic [DATA_WIDTH-1:0] reg_write_data_o,
  output logic [1:0]            occupancy,
  input  logic [ADDR_WIDTH-1:0] fwd_addr,
  output logic                  fwd_hit,
  output logic [DATA_WIDTH-1:0] fwd_data
);

  // Encoding doubles as the occupancy count, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic [ADDR_WIDTH-1:0] head_addr_q, head_addr_d, skid_addr_q, skid_addr_d;
  logic                  head_en_q, head_en_d, skid_en_q, skid_en_d;
  logic [DATA_WIDTH-1:0] head_data_q, head_data_d, skid_data_q, skid_data_d;
  logic                  push, pop;

  // Handshake: a transfer happens on an edge where valid && ready are both 1.
  assign push = in_valid && in_ready_q;
  assign pop  = (state_q != EMPTY) && out_ready;

  always_comb begin
    state_d     = state_q;
    head_addr_d = head_addr_q;
    head_en_d   = head_en_q;
    head_data_d = head_data_q;
    skid_addr_d = skid_addr_q;
    skid_en_d   = skid_en_q;
    skid_data_d = skid_data_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          head_addr_d = reg_write_addr_i;
          head_en_d   = reg_write_en_i;
          head_data_d = reg_write_data_i;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_addr_d = reg_write_addr_i;
          head_en_d   = reg_write_en_i;
          head_data_d = reg_write_data_i;
        end else if (push) begin
          skid_addr_d = reg_write_addr_i;
          skid_en_d   = reg_write_en_i;
          skid_data_d = reg_write_data_i;
          state_d     = FULL;
        end else if (pop) begin
          head_addr_d = '0;
          head_en_d   = 1'b0;
          head_data_d = '0;
          state_d     = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_addr_d = skid_addr_q;
          head_en_d   = skid_en_q;
          head_data_d = skid_data_q;
          skid_addr_d = '0;
          skid_en_d   = 1'b0;
          skid_data_d = '0;
          state_d     = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d     = EMPTY;
      head_addr_d = '0;
      head_en_d   = 1'b0;
      head_data_d = '0;
      skid_addr_d = '0;
      skid_en_d   = 1'b0;
      skid_data_d = '0;
    end
    // Registered ready: a free slot is guaranteed whenever it reads 1.
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b0;
      head_addr_q <= '0;
      head_en_q   <= 1'b0;
      head_data_q <= '0;
      skid_addr_q <= '0;
      skid_en_q   <= 1'b0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      head_addr_q <= head_addr_d;
      head_en_q   <= head_en_d;
      head_data_q <= head_data_d;
      skid_addr_q <= skid_addr_d;
      skid_en_q   <= skid_en_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign in_ready         = in_ready_q;
  assign out_valid        = (state_q != EMPTY);
  assign reg_write_addr_o = out_valid ? head_addr_q : '0;
  assign reg_write_en_o   = out_valid & head_en_q;
  assign reg_write_data_o = out_valid ? head_data_q : '0;
  assign occupancy        = state_q;

  // Skid holds the newer entry, so it wins over head; r0 never forwards.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_addr != '0) begin
      if ((state_q == FULL) && skid_en_q && (skid_addr_q == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = skid_data_q;
      end else if ((state_q != EMPTY) && head_en_q && (head_addr_q == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = head_data_q;
      end
    end
  end

endmodule

// File: doc/ex_mem_buffer.md
# ex_mem_buffer

EX→MEM pipeline buffer for the in-order core. It captures the execute-stage write-back triple (destination address, write enable, result data) and holds it behind a valid/ready handshake. A two-entry skid buffer gives a registered `in_ready`, so a MEM stall never forms a combinational path back into EX. It also exposes a combinational forwarding lookup over its stored entries for the decode-stage bypass.

## Interface
- DATA_WIDTH, 32, width of result data
- ADDR_WIDTH, 5, width of register address
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous discard of all held and incoming entries
- in_valid  in  1  EX presents an entry
- in_ready  out  ADDR-independent 1  buffer can accept (registered)
- reg_write_addr_i  in  ADDR_WIDTH  destination register from EX
- reg_write_en_i  in  1  write enable from EX
- reg_write_data_i  in  DATA_WIDTH  result from EX
- out_valid  out  1  head entry valid toward MEM
- out_ready  in  1  MEM consumes head
- reg_write_addr_o  out  ADDR_WIDTH  head destination
- reg_write_en_o  out  1  head write enable, gated by out_valid
- reg_write_data_o  out  DATA_WIDTH  head result
- occupancy  out  2  entries held (0, 1 or 2)
- fwd_addr  in  ADDR_WIDTH  register being looked up by decode
- fwd_hit  out  1  a held entry writes fwd_addr
- fwd_data  out  DATA_WIDTH  forwarded value, 0 when no hit

## Operation
- Storage consists of a head register (drives the outputs) and a skid register. States: EMPTY (0 entries), ONE (head only), FULL (head and skid).
- A push occurs when in_valid && in_ready. A pop occurs when out_valid && out_ready.
- Transitions without flush:
  - EMPTY: push loads head → ONE.
  - ONE: push only loads skid → FULL. Push and pop together loads head with the new entry → ONE. Pop only → EMPTY.
  - FULL: no push is possible. Pop moves skid to head → ONE. No pop holds FULL.
- flush has the highest priority. The next state is EMPTY and any same-cycle push or pop is discarded. Registers are cleared to 0.
- in_ready is a flop:
  - next value is 1 when the next state ≠ FULL; 0 otherwise.
  - reset value is 0; it rises at the first clk edge after rst deasserts.
- out_valid = (state ≠ EMPTY). reg_write_en_o = out_valid & head_en. Payload outputs are 0 while EMPTY.
- occupancy encodes the state directly: EMPTY=0, ONE=1, FULL=2.
- Forwarding (combinational):
  - An entry matches when it is valid, its en=1, its addr == fwd_addr, and fwd_addr ≠ 0.
  - The skid entry is newer and has priority over the head.
  - fwd_hit=1 on any match; fwd_data is the matching entry's data.
  - Incoming in_* values are never forwarded.
- Entries with en=0 are stored and popped normally (they occupy a slot).

## Timing
- On rst assertion, regardless of clk: state EMPTY, in_ready=0, out_valid=0, all payload outputs 0, occupancy=0, fwd_hit=0, fwd_data=0.
- Latency: an entry pushed at edge N is visible on the outputs after edge N (out_valid=1 in cycle N+1) when it lands in head. Minimum residence is one cycle.
- Throughput: one entry per cycle with out_ready held at 1. The skid register is used only when out_ready=0 at push.
- in_ready falls in the cycle after the buffer becomes FULL. It rises in the cycle after the pop from FULL. No push is lost, because in_ready=1 implies at least one free slot at that edge.
- out_valid must not drop without a pop or flush. Payload is stable while out_valid && !out_ready.
- Reset released mid-traffic: entries presented while in_ready=0 are not accepted. EX must hold them.

## Test plan
- Reset: assert rst between edges → all outputs 0 immediately. Deassert → in_ready=1 after the next edge, occupancy=0.
- Streaming: push addr 3/4/5 with data 0x11/0x22/0x33, en=1, out_ready=1 → identical sequence at outputs one cycle later, occupancy stays 1, in_ready stays 1.
- Backpressure: out_ready=0, push addr 7 data 0xA then addr 8 data 0xB → occupancy=2 and in_ready=0 the next cycle. Raise out_ready → 0xA then 0xB, with in_ready=1 after the first pop.
- Flush while FULL with a simultaneous pop and in_valid → next cycle occupancy=0, out_valid=0, reg_write_en_o=0, in_ready=1, no entry emitted.
- Forwarding: head addr 9 data 0x100, skid addr 9 data 0x200, fwd_addr=9 → fwd_hit=1, fwd_data=0x200.
  - fwd_addr=0 → fwd_hit=0.
  - Head addr 9 with en=0 only → fwd_hit=0.
- en=0 entry: push addr 6 en=0 data 0xFF → out_valid=1, reg_write_en_o=0, occupancy=1, popped normally.
